ecc_scalar_mult_ctrl: RTL and testbench
=======================================

Name: ecc_scalar_mult_ctrl

Overview:
- Sequencer for left-to-right double-and-add scalar multiplication R = k·P over GF(p).
- Owns no field arithmetic. It drives one point-doubling unit and one point-addition unit through start/done handshakes and holds the accumulator point Q.
- Resolves point-at-infinity and P==±Q special cases itself, so the arithmetic units only ever see valid general-case operands.
- Sits between the top-level ECC wrapper and the doubling/addition datapaths.

Parameters:
- N, 231, field element width in bits.
- K, 231, scalar width in bits.
- TIMEOUT, 65535, maximum cycles to wait for any unit done before the operation is aborted.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- start  in  1  one-cycle request; accepted only when busy=0
- k  in  K  scalar
- px, py  in  N  base point P
- p, a  in  N  field modulus and curve coefficient a; latched on start
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse when the result is valid
- err  out  1  set with done on timeout; cleared on next accepted start
- rx, ry  out  N  result coordinates; held until the next accepted start
- r_inf  out  1  result is the point at infinity
- dbl_start  out  1  one-cycle pulse to the doubling unit
- dbl_x, dbl_y  out  N  doubling operand; stable from dbl_start until dbl_done
- dbl_done  in  1  doubling result valid
- dbl_rx, dbl_ry  in  N  doubling result
- dbl_inf  in  1  doubling result is infinity
- add_start  out  1  one-cycle pulse to the addition unit
- add_x1, add_y1, add_x2, add_y2  out  N  addition operands Q and P; stable until add_done
- add_done  in  1  addition result valid
- add_rx, add_ry  in  N  addition result
- op_p, op_a  out  N  latched p and a, driven to both units

Behaviour:
- Reset values: busy=0, done=0, err=0, rx=ry=0, r_inf=1, dbl_start=add_start=0, all operand outputs 0, state IDLE, Q=infinity.
- Reset asserted mid-operation returns the block to IDLE in the next cycle. No done pulse is issued. Late dbl_done/add_done are ignored outside the WAIT states.
- States: IDLE, BIT, DBL_REQ, DBL_WAIT, ADD_CHK, ADD_REQ, ADD_WAIT, NEXT, FIN.
- IDLE: on start, latch k, px, py, p, a; set i=K-1, Q=inf (q_inf=1), err=0, busy=1; go to BIT. start is ignored while busy=1.
- BIT: if q_inf, skip doubling and go to ADD_CHK. Otherwise go to DBL_REQ with dbl operand = Q.
- DBL_REQ: pulse dbl_start for exactly 1 cycle; go to DBL_WAIT.
- DBL_WAIT: on dbl_done, Q ← (dbl_rx, dbl_ry) and q_inf ← dbl_inf. Then:
  - if this doubling came from the P==Q add case, go to NEXT;
  - otherwise go to ADD_CHK.
- ADD_CHK (one cycle):
  - k[i]=0: go to NEXT.
  - q_inf: Q ← P, q_inf=0; go to NEXT. No unit call.
  - Qx==Px and Qy==Py: go to DBL_REQ with operand P, flagged as an add-doubling.
  - Qx==Px and Qy≠Py: q_inf ← 1; go to NEXT.
  - Otherwise: go to ADD_REQ.
- ADD_REQ: pulse add_start for 1 cycle with (Q, P); go to ADD_WAIT.
- ADD_WAIT: on add_done, Q ← (add_rx, add_ry); go to NEXT.
- NEXT: if i==0, go to FIN; else i ← i-1 and go to BIT.
- FIN: rx, ry ← Q (0,0 if q_inf); r_inf ← q_inf; done=1 for 1 cycle; busy=0; go to IDLE.
- Timeout: a wait counter clears on each *_start. If it reaches TIMEOUT in either WAIT state, go to FIN with err=1, r_inf=1, rx=ry=0.
- A done input arriving in the same cycle as the timeout wins; the timeout is not taken.
- Never assert dbl_start and add_start together. Never issue a new start before the previous done.
- Equality comparisons are full-width N-bit. No modular reduction is done in this block.

Decomposition:
- Shared package ecc_ctrl_pkg holds: the state enum, the op-source flag encoding (NORMAL / ADD_AS_DBL), and the bit-index width $clog2(K).
- No sub-module is needed; the single FSM plus the wait counter fits in one module.
- The bench provides behavioural doubling and addition models with a programmable latency L.

Test Plan:
All scenarios use p=17, a=2, P=(5,1) (group order 19), K=8, unit latency L=4.
- k=0 -> done with r_inf=1, rx=ry=0, err=0; dbl_start and add_start never pulse.
- k=1 -> rx=5, ry=1, r_inf=0; zero unit calls.
- k=3 -> exactly 1 dbl call with operand (5,1) and 1 add call with operands (6,3),(5,1); result (10,6).
- k=19 -> 4 dbl calls and 1 add call; the final ADD_CHK sees 18P = -P, giving r_inf=1 with no add call for that bit.
- k=3 with the doubling model never answering -> done after TIMEOUT+overhead cycles with err=1, r_inf=1; a fresh start then clears err.
- k=3 with reset pulsed during DBL_WAIT, then a late dbl_done -> no done pulse, busy=0, and a subsequent start completes correctly.

Source files
------------

// File: rtl/ecc_ctrl_pkg.sv
// Shared types for the scalar-multiplication sequencer: FSM states, the
// operation-source flag and the bit-index width helper.
package ecc_ctrl_pkg;

  typedef enum logic [3:0] {
    IDLE,
    BIT,
    DBL_REQ,
    DBL_WAIT,
    ADD_CHK,
    ADD_REQ,
    ADD_WAIT,
    NEXT,
    FIN
  } state_t;

  typedef enum logic {
    NORMAL,
    ADD_AS_DBL
  } op_src_t;

  function automatic int idx_width(input int k);
    return (k > 1) ? $clog2(k) : 1;
  endfunction

endpackage

// File: rtl/ecc_scalar_mult_ctrl.sv
// Left-to-right double-and-add sequencer for R = k*P; drives external point
// doubling/addition units and resolves infinity and P == +/-Q cases locally.
module ecc_scalar_mult_ctrl
  import ecc_ctrl_pkg::*;
#(
  parameter int N       = 231,
  parameter int K       = 231,
  parameter int TIMEOUT = 65535
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [K-1:0] k,
  input  logic [N-1:0] px,
  input  logic [N-1:0] py,
  input  logic [N-1:0] p,
  input  logic [N-1:0] a,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [N-1:0] rx,
  output logic [N-1:0] ry,
  output logic         r_inf,
  output logic         dbl_start,
  output logic [N-1:0] dbl_x,
  output logic [N-1:0] dbl_y,
  input  logic         dbl_done,
  input  logic [N-1:0] dbl_rx,
  input  logic [N-1:0] dbl_ry,
  input  logic         dbl_inf,
  output logic         add_start,
  output logic [N-1:0] add_x1,
  output logic [N-1:0] add_y1,
  output logic [N-1:0] add_x2,
  output logic [N-1:0] add_y2,
  input  logic         add_done,
  input  logic [N-1:0] add_rx,
  input  logic [N-1:0] add_ry,
  output logic [N-1:0] op_p,
  output logic [N-1:0] op_a
);

  localparam int IW = idx_width(K);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [IW-1:0] I_TOP   = IW'(K - 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

  state_t         state, state_n;
  op_src_t        src;
  logic [K-1:0]   k_r;
  logic [N-1:0]   px_r, py_r, qx, qy;
  logic           q_inf, to_flag;
  logic [IW-1:0]  idx;
  logic [CW-1:0]  cnt;

  logic accept, dbl_ld_q, dbl_ld_p, add_ld;
  logic q_ld_dbl, q_ld_add, q_ld_p, q_kill;
  logic i_dec, to_hit, cnt_clr, cnt_inc, fin;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n   = state;
    dbl_start = 1'b0;
    add_start = 1'b0;
    accept    = 1'b0;
    dbl_ld_q  = 1'b0;
    dbl_ld_p  = 1'b0;
    add_ld    = 1'b0;
    q_ld_dbl  = 1'b0;
    q_ld_add  = 1'b0;
    q_ld_p    = 1'b0;
    q_kill    = 1'b0;
    i_dec     = 1'b0;
    to_hit    = 1'b0;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    fin       = 1'b0;
    case (state)
      IDLE: if (start) begin
        accept  = 1'b1;
        state_n = BIT;
      end
      BIT: begin
        if (q_inf) state_n = ADD_CHK;
        else begin
          dbl_ld_q = 1'b1;
          state_n  = DBL_REQ;
        end
      end
      DBL_REQ: begin
        dbl_start = 1'b1;
        cnt_clr   = 1'b1;
        state_n   = DBL_WAIT;
      end
      // A done arriving on the timeout cycle takes priority over the abort.
      DBL_WAIT: begin
        if (dbl_done) begin
          q_ld_dbl = 1'b1;
          state_n  = (src == ADD_AS_DBL) ? NEXT : ADD_CHK;
        end else if (cnt == CNT_MAX) begin
          to_hit  = 1'b1;
          state_n = FIN;
        end else cnt_inc = 1'b1;
      end
      ADD_CHK: begin
        if (!k_r[idx]) state_n = NEXT;
        else if (q_inf) begin
          q_ld_p  = 1'b1;
          state_n = NEXT;
        end else if (qx == px_r) begin
          if (qy == py_r) begin
            dbl_ld_p = 1'b1;
            state_n  = DBL_REQ;
          end else begin
            q_kill  = 1'b1;
            state_n = NEXT;
          end
        end else begin
          add_ld  = 1'b1;
          state_n = ADD_REQ;
        end
      end
      ADD_REQ: begin
        add_start = 1'b1;
        cnt_clr   = 1'b1;
        state_n   = ADD_WAIT;
      end
      ADD_WAIT: begin
        if (add_done) begin
          q_ld_add = 1'b1;
          state_n  = NEXT;
        end else if (cnt == CNT_MAX) begin
          to_hit  = 1'b1;
          state_n = FIN;
        end else cnt_inc = 1'b1;
      end
      NEXT: begin
        if (idx == '0) state_n = FIN;
        else begin
          i_dec   = 1'b1;
          state_n = BIT;
        end
      end
      FIN: begin
        fin     = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      rx      <= '0;
      ry      <= '0;
      r_inf   <= 1'b1;
      dbl_x   <= '0;
      dbl_y   <= '0;
      add_x1  <= '0;
      add_y1  <= '0;
      add_x2  <= '0;
      add_y2  <= '0;
      op_p    <= '0;
      op_a    <= '0;
      k_r     <= '0;
      px_r    <= '0;
      py_r    <= '0;
      qx      <= '0;
      qy      <= '0;
      q_inf   <= 1'b1;
      src     <= NORMAL;
      idx     <= '0;
      cnt     <= '0;
      to_flag <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        k_r     <= k;
        px_r    <= px;
        py_r    <= py;
        op_p    <= p;
        op_a    <= a;
        idx     <= I_TOP;
        qx      <= '0;
        qy      <= '0;
        q_inf   <= 1'b1;
        err     <= 1'b0;
        to_flag <= 1'b0;
        busy    <= 1'b1;
      end
      if (dbl_ld_q) begin
        dbl_x <= qx;
        dbl_y <= qy;
        src   <= NORMAL;
      end
      if (dbl_ld_p) begin
        dbl_x <= px_r;
        dbl_y <= py_r;
        src   <= ADD_AS_DBL;
      end
      if (add_ld) begin
        add_x1 <= qx;
        add_y1 <= qy;
        add_x2 <= px_r;
        add_y2 <= py_r;
      end
      if (q_ld_dbl) begin
        qx    <= dbl_rx;
        qy    <= dbl_ry;
        q_inf <= dbl_inf;
      end
      if (q_ld_add) begin
        qx <= add_rx;
        qy <= add_ry;
      end
      if (q_ld_p) begin
        qx    <= px_r;
        qy    <= py_r;
        q_inf <= 1'b0;
      end
      if (q_kill) q_inf <= 1'b1;
      if (cnt_clr)      cnt <= '0;
      else if (cnt_inc) cnt <= cnt + 1'b1;
      if (i_dec)  idx     <= idx - 1'b1;
      if (to_hit) to_flag <= 1'b1;
      if (fin) begin
        done <= 1'b1;
        busy <= 1'b0;
        if (to_flag) begin
          err   <= 1'b1;
          r_inf <= 1'b1;
          rx    <= '0;
          ry    <= '0;
        end else begin
          r_inf <= q_inf;
          rx    <= q_inf ? '0 : qx;
          ry    <= q_inf ? '0 : qy;
        end
      end
    end
  end

endmodule

// File: tb/tb_ecc_scalar_mult_ctrl.sv
// Bench for ecc_scalar_mult_ctrl on y^2 = x^3 + 2x + 2 over GF(17), P = (5,1),
// with behavioural doubling/addition units of programmable latency.
module tb_ecc_scalar_mult_ctrl;

  localparam int NW  = 8;
  localparam int KW  = 8;
  localparam int TMO = 40;
  localparam int PM  = 17;
  localparam int AC  = 2;

  typedef struct {
    int x;
    int y;
    bit inf;
  } pt_t;

  logic          clk, reset, start;
  logic [KW-1:0] k_in;
  logic [NW-1:0] px, py, p, a;
  logic          busy, done, err, r_inf;
  logic [NW-1:0] rx, ry;
  logic          dbl_start, dbl_done, dbl_inf;
  logic [NW-1:0] dbl_x, dbl_y, dbl_rx, dbl_ry;
  logic          add_start, add_done;
  logic [NW-1:0] add_x1, add_y1, add_x2, add_y2, add_rx, add_ry;
  logic [NW-1:0] op_p, op_a;

  ecc_scalar_mult_ctrl #(.N(NW), .K(KW), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .start(start), .k(k_in),
    .px(px), .py(py), .p(p), .a(a),
    .busy(busy), .done(done), .err(err), .rx(rx), .ry(ry), .r_inf(r_inf),
    .dbl_start(dbl_start), .dbl_x(dbl_x), .dbl_y(dbl_y),
    .dbl_done(dbl_done), .dbl_rx(dbl_rx), .dbl_ry(dbl_ry), .dbl_inf(dbl_inf),
    .add_start(add_start), .add_x1(add_x1), .add_y1(add_y1),
    .add_x2(add_x2), .add_y2(add_y2),
    .add_done(add_done), .add_rx(add_rx), .add_ry(add_ry),
    .op_p(op_p), .op_a(op_a)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int md(input int v);
    return ((v % PM) + PM) % PM;
  endfunction

  function automatic int inv(input int v);
    int r = 1;
    for (int i = 0; i < PM - 2; i++) r = md(r * v);
    return r;
  endfunction

  // Full affine group law, including identity and inverse cases.
  function automatic pt_t padd(input pt_t u, input pt_t w);
    pt_t r;
    int  l;
    r.x = 0; r.y = 0; r.inf = 1'b0;
    if (u.inf) return w;
    if (w.inf) return u;
    if (u.x == w.x) begin
      if (md(u.y + w.y) == 0) begin
        r.inf = 1'b1;
        return r;
      end
      l = md(md(3 * u.x * u.x + AC) * inv(md(2 * u.y)));
    end else begin
      l = md(md(w.y - u.y) * inv(md(w.x - u.x)));
    end
    r.x = md(l * l - u.x - w.x);
    r.y = md(l * (u.x - r.x) - u.y);
    return r;
  endfunction

  function automatic pt_t base();
    pt_t b;
    b.x = 5; b.y = 1; b.inf = 1'b0;
    return b;
  endfunction

  // Result reference: k repeated additions of P.
  function automatic pt_t smul(input int kv);
    pt_t q;
    q.x = 0; q.y = 0; q.inf = 1'b1;
    for (int n = 0; n < kv; n++) q = padd(q, base());
    return q;
  endfunction

  // Unit-call counts implied by the double-and-add rules with local special cases.
  function automatic void calls(input int kv, output int nd, output int na);
    pt_t q;
    q.x = 0; q.y = 0; q.inf = 1'b1;
    nd = 0; na = 0;
    for (int i = KW - 1; i >= 0; i--) begin
      if (!q.inf) begin nd++; q = padd(q, q); end
      if (kv[i]) begin
        if (q.inf) q = base();
        else if (q.x == 5 && q.y == 1) begin nd++; q = padd(q, q); end
        else if (q.x == 5) q.inf = 1'b1;
        else begin na++; q = padd(q, base()); end
      end
    end
  endfunction

  int  lat = 4;
  bit  dbl_mute = 1'b0;
  int  dbl_left = -1, add_left = -1;
  int  dbl_calls = 0, add_calls = 0, done_cnt = 0, overlap = 0;
  pt_t dbl_op, add_op1, add_op2;
  int  first_dx, first_dy, first_ax1, first_ay1, first_ax2, first_ay2;

  always @(negedge clk) begin
    pt_t r;
    dbl_done = 1'b0;
    if (dbl_left > 0) dbl_left--;
    else if (dbl_left == 0) begin
      r = padd(dbl_op, dbl_op);
      dbl_rx = r.inf ? '0 : NW'(r.x);
      dbl_ry = r.inf ? '0 : NW'(r.y);
      dbl_inf = r.inf;
      dbl_done = 1'b1;
      dbl_left = -1;
    end
    if (dbl_start) begin
      if (dbl_calls == 0) begin first_dx = int'(dbl_x); first_dy = int'(dbl_y); end
      dbl_calls++;
      dbl_op.x = int'(dbl_x); dbl_op.y = int'(dbl_y); dbl_op.inf = 1'b0;
      if (!dbl_mute) dbl_left = lat - 1;
    end
  end

  always @(negedge clk) begin
    pt_t r;
    add_done = 1'b0;
    if (add_left > 0) add_left--;
    else if (add_left == 0) begin
      r = padd(add_op1, add_op2);
      add_rx = NW'(r.x);
      add_ry = NW'(r.y);
      add_done = 1'b1;
      add_left = -1;
    end
    if (add_start) begin
      if (add_calls == 0) begin
        first_ax1 = int'(add_x1); first_ay1 = int'(add_y1);
        first_ax2 = int'(add_x2); first_ay2 = int'(add_y2);
      end
      add_calls++;
      add_op1.x = int'(add_x1); add_op1.y = int'(add_y1); add_op1.inf = 1'b0;
      add_op2.x = int'(add_x2); add_op2.y = int'(add_y2); add_op2.inf = 1'b0;
      add_left = lat - 1;
    end
  end

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (dbl_start && add_start) overlap++;
  end

  task automatic run_op(input int kv, input int lat_v, input bit mute, input bit poke);
    pt_t e;
    int  cyc, ed, ea;
    lat = lat_v;
    dbl_mute = mute;
    dbl_calls = 0;
    add_calls = 0;
    @(negedge clk);
    k_in = KW'(kv);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    cyc = 0;
    while (cyc < TMO + 1000) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (done) break;
      if (poke && cyc == 2) begin
        start = 1'b1;
        k_in = ~KW'(kv);
      end
    end
    start = 1'b0;
    chk("done_reached", done, 1);
    chk("busy_at_done", busy, 0);
    if (mute) begin
      chk("tmo_err", err, 1);
      chk("tmo_rinf", r_inf, 1);
      chk("tmo_rx", rx, 0);
      chk("tmo_ry", ry, 0);
      chk("tmo_latency", (cyc > TMO) ? 1 : 0, 1);
      chk("tmo_dbl_calls", dbl_calls, 1);
    end else begin
      e = smul(kv);
      calls(kv, ed, ea);
      chk("res_rx", rx, e.inf ? 0 : e.x);
      chk("res_ry", ry, e.inf ? 0 : e.y);
      chk("res_rinf", r_inf, e.inf);
      chk("res_err", err, 0);
      chk("dbl_calls", dbl_calls, ed);
      chk("add_calls", add_calls, ea);
    end
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("no_overlap", overlap, 0);
  endtask

  initial begin
    int c, d0;
    reset = 1'b1; start = 1'b0; k_in = '0;
    px = 8'd5; py = 8'd1; p = 8'd17; a = 8'd2;
    dbl_done = 1'b0; dbl_inf = 1'b0; dbl_rx = '0; dbl_ry = '0;
    add_done = 1'b0; add_rx = '0; add_ry = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_rx", rx, 0);
    chk("rst_ry", ry, 0);
    chk("rst_rinf", r_inf, 1);
    chk("rst_dbl_start", dbl_start, 0);
    chk("rst_add_start", add_start, 0);
    chk("rst_dbl_x", dbl_x, 0);
    chk("rst_add_x1", add_x1, 0);
    chk("rst_op_p", op_p, 0);
    reset = 1'b0;

    run_op(0, 4, 1'b0, 1'b0);
    chk("k0_rinf", r_inf, 1);
    chk("k0_dbl", dbl_calls, 0);
    chk("k0_add", add_calls, 0);
    chk("op_p_latched", op_p, 17);
    chk("op_a_latched", op_a, 2);

    run_op(1, 4, 1'b0, 1'b0);
    chk("k1_rx", rx, 5);
    chk("k1_ry", ry, 1);
    chk("k1_calls", dbl_calls + add_calls, 0);

    run_op(3, 4, 1'b0, 1'b0);
    chk("k3_rx", rx, 10);
    chk("k3_ry", ry, 6);
    chk("k3_dbl", dbl_calls, 1);
    chk("k3_add", add_calls, 1);
    chk("k3_dbl_op", (first_dx << 8) | first_dy, (5 << 8) | 1);
    chk("k3_add_op", (first_ax1 << 24) | (first_ay1 << 16) | (first_ax2 << 8) | first_ay2,
        (6 << 24) | (3 << 16) | (5 << 8) | 1);

    run_op(19, 4, 1'b0, 1'b0);
    chk("k19_rinf", r_inf, 1);
    chk("k19_dbl", dbl_calls, 4);
    chk("k19_add", add_calls, 1);

    run_op(3, 4, 1'b1, 1'b0);
    run_op(3, 4, 1'b0, 1'b0);
    chk("err_cleared", err, 0);

    // Reset while the doubling unit is still working; its late answer must be ignored.
    lat = 4; dbl_mute = 1'b0;
    @(negedge clk);
    k_in = 8'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    c = 0;
    while (c < 100 && !dbl_start) begin @(negedge clk); c++; end
    chk("rst_test_dbl_start", dbl_start, 1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    d0 = done_cnt;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    repeat (10) @(negedge clk);
    chk("midrst_no_done", done_cnt - d0, 0);
    chk("midrst_busy_late", busy, 0);
    run_op(3, 4, 1'b0, 1'b0);

    for (int t = 0; t < 8; t++)
      run_op(int'($urandom_range(0, 255)), int'($urandom_range(1, 6)), 1'b0, t[0]);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
